// File: rtl/ex3_to_bin_pkg.sv
// Shared constants for the excess-3 to binary converter.
package ex3_to_bin_pkg;
    localparam logic [3:0] EX3_OFFSET = 4'd3;
    localparam logic [3:0] EX3_MIN    = 4'd3;
    localparam logic [3:0] EX3_MAX    = 4'd12;
    localparam int         DEF_CNT_W  = 8;
endpackage

// File: rtl/ex3_to_bin_decode.sv
// Combinational excess-3 digit decoder: wrapped value plus invalid-code flag.
module ex3_decode
    import ex3_to_bin_pkg::*;
(
    input  logic [3:0] e,
    output logic [3:0] value,
    output logic       invalid
);

    always_comb begin
        // Invalid codes still yield the 4-bit wrapped difference
        value   = e - EX3_OFFSET;
        invalid = (e < EX3_MIN) || (e > EX3_MAX);
    end

endmodule

// File: rtl/ex3_to_bin.sv
// Registered excess-3 to binary converter with sticky error flag and
// saturating invalid-code counter.
module ex3_to_bin
    import ex3_to_bin_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       e,
    input  logic             in_valid,
    output logic [4:0]       b,
    output logic             out_valid,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    logic [1:0]       rst_sync_q, rst_sync_d;
    logic             rst_int_n;
    logic [3:0]       dec_value;
    logic             dec_invalid;
    logic [4:0]       b_q, b_d;
    logic             out_valid_q, out_valid_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    // Reset asserts immediately but releases only after two clean clock edges
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_int_n  = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    ex3_decode u_decode (
        .e       (e),
        .value   (dec_value),
        .invalid (dec_invalid)
    );

    always_comb begin
        b_d          = b_q;
        out_valid_d  = in_valid;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        if (in_valid) begin
            b_d = {dec_invalid, dec_value};
            if (dec_invalid) begin
                err_sticky_d = 1'b1;
                err_cnt_d    = sat_inc(err_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            b_q          <= 5'b00000;
            out_valid_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            b_q          <= b_d;
            out_valid_q  <= out_valid_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign b          = b_q;
    assign out_valid  = out_valid_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ex3_to_bin.sv
// Self-checking bench for ex3_to_bin: default and CNT_W=2 instances share stimulus.
module tb_ex3_to_bin;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] e_i;
    logic       in_valid;
    logic [4:0] b8, b2;
    logic       ov8, ov2, st8, st2;
    logic [7:0] c8;
    logic [1:0] c2;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int   m_b, m_ov, m_st, m_c8, m_c2, rel;
    logic s_rn, s_iv;
    int   s_e, inv;

    always #5 clk = ~clk;

    ex3_to_bin dut8 (
        .clk(clk), .rst_n(rst_n), .e(e_i), .in_valid(in_valid),
        .b(b8), .out_valid(ov8), .err_sticky(st8), .err_cnt(c8)
    );

    ex3_to_bin #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .e(e_i), .in_valid(in_valid),
        .b(b2), .out_valid(ov2), .err_sticky(st2), .err_cnt(c2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: reset holds outputs at zero until two edges after release,
    // then each valid digit maps to (e+13)%16 with bit 4 marking codes outside 3..12.
    always @(posedge clk) begin
        s_rn = rst_n;
        s_iv = in_valid;
        s_e  = int'(e_i);
        if (!s_rn) begin
            m_b = 0; m_ov = 0; m_st = 0; m_c8 = 0; m_c2 = 0; rel = 0;
        end else begin
            if (rel >= 2) begin
                m_ov = s_iv ? 1 : 0;
                if (s_iv) begin
                    inv = (s_e < 3 || s_e > 12) ? 1 : 0;
                    m_b = inv * 16 + (s_e + 13) % 16;
                    if (inv == 1) begin
                        m_st = 1;
                        m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
                        m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
                    end
                end
            end else begin
                rel++;
            end
        end
        #1;
        chk("model_b8", int'(b8), m_b);
        chk("model_ov8", int'(ov8), m_ov);
        chk("model_st8", int'(st8), m_st);
        chk("model_cnt8", int'(c8), m_c8);
        chk("model_b2", int'(b2), m_b);
        chk("model_ov2", int'(ov2), m_ov);
        chk("model_st2", int'(st2), m_st);
        chk("model_cnt2", int'(c2), m_c2);
    end

    task automatic apply(input logic [3:0] ev, input logic v);
        @(negedge clk);
        e_i      = ev;
        in_valid = v;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_b"}, int'(b8), 0);
        chk({tag, "_ov"}, int'(ov8), 0);
        chk({tag, "_st"}, int'(st8), 0);
        chk({tag, "_cnt8"}, int'(c8), 0);
        chk({tag, "_cnt2"}, int'(c2), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    logic [4:0] sweep_exp [16];
    int         sat_exp [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sweep_exp = '{5'b11101, 5'b11110, 5'b11111, 5'b00000, 5'b00001, 5'b00010,
                      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                      5'b01001, 5'b11010, 5'b11011, 5'b11100};
        sat_exp   = '{1, 2, 3, 3, 3};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        e_i      = 4'd0;
        #2;
        chk_zero("rst_init");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // valid boundary codes leave the error state untouched
        apply(4'd3, 1'b1);
        chk("e3_b", int'(b8), 5'b00000);
        chk("e3_ov", int'(ov8), 1);
        chk("e3_st", int'(st8), 0);
        apply(4'd12, 1'b1);
        chk("e12_b", int'(b8), 5'b01001);
        chk("e12_st", int'(st8), 0);

        // idle cycle with an invalid code on the bus
        apply(4'd15, 1'b0);
        chk("idle_b", int'(b8), 5'b01001);
        chk("idle_ov", int'(ov8), 0);
        chk("idle_cnt", int'(c8), 0);

        apply(4'd0, 1'b1);
        chk("e0_b", int'(b8), 5'b11101);
        chk("e0_ov", int'(ov8), 1);
        chk("e0_st", int'(st8), 1);
        chk("e0_cnt", int'(c8), 1);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(4'(i), 1'b1);
            chk($sformatf("sweep_b_%0d", i), int'(b8), int'(sweep_exp[i]));
        end
        chk("sweep_cnt8", int'(c8), 6);
        chk("sweep_cnt2", int'(c2), 3);
        chk("sweep_st", int'(st8), 1);
        apply(4'd0, 1'b0);

        do_reset();
        for (int k = 0; k < 5; k++) begin
            apply(4'd14, 1'b1);
            chk($sformatf("sat_cnt2_%0d", k), int'(c2), sat_exp[k]);
        end
        chk("sat_cnt8", int'(c8), 5);
        chk("sat_b", int'(b2), 5'b11011);

        // reset asserted between edges with a conversion in flight
        apply(4'd0, 1'b1);
        apply(4'd7, 1'b1);
        chk("flight_b", int'(b8), 5'b00100);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #2;
            chk("post_rst_ov", int'(ov8), 0);
        end
        apply(4'd5, 1'b1);
        chk("after_b", int'(b8), 5'b00010);
        chk("after_ov", int'(ov8), 1);
        chk("after_cnt", int'(c8), 0);

        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex3_to_bin.md
EX3_TO_BIN -- requirements
Module: ex3_to_bin

Interface
REQ-001 Parameter CNT_W, default 8, width of the saturating invalid-code counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 e  input  4  excess-3 coded digit to convert.
REQ-005 in_valid  input  1  e is sampled and converted this cycle when high.
REQ-006 b  output  5  b[3:0] = binary value, b[4] = invalid-code flag for that conversion.
REQ-007 out_valid  output  1  b holds a fresh conversion this cycle.
REQ-008 err_sticky  output  1  set once any invalid code has been converted; cleared only by reset.
REQ-009 err_cnt  output  CNT_W  number of invalid codes converted, saturating.

Function
REQ-010 Conversion: b[3:0] SHALL equal (e - 3) mod 16, using 4-bit wrap-around arithmetic.
REQ-011 Valid excess-3 codes are 3..12 inclusive; b[4] SHALL be 0 for these codes and 1 for e in {0,1,2,13,14,15}.
REQ-012 Invalid codes SHALL still produce the wrapped difference on b[3:0]: e=0->13, 1->14, 2->15, 13->10, 14->11, 15->12.
REQ-013 Latency SHALL be exactly one cycle: e sampled with in_valid=1 at edge N appears on b with out_valid=1 after edge N.
REQ-014 out_valid SHALL be a one-cycle-delayed copy of in_valid; no backpressure, one conversion per cycle sustained.
REQ-015 When in_valid=0, b SHALL hold its last value and out_valid SHALL be 0.
REQ-016 err_cnt SHALL increment by 1 on each accepted invalid code and saturate at 2^CNT_W-1 without wrap.
REQ-017 err_sticky SHALL rise in the same cycle out_valid=1 and b[4]=1 first occur.
REQ-018 err_cnt and err_sticky SHALL update in the same cycle as the corresponding b/out_valid.
REQ-019 Back-to-back inputs SHALL each be converted independently; no state other than the counter and sticky flag carries between conversions.

Reset
REQ-020 While rst_n=0: b=5'b00000, out_valid=0, err_sticky=0, err_cnt=0, asynchronously.
REQ-021 Assertion of rst_n mid-stream SHALL discard the in-flight conversion; the first conversion after deassertion needs a new in_valid.
REQ-022 rst_n deassertion SHALL be synchronised to clk internally before releasing the registers.

Structure
REQ-023 Shared package ex3_to_bin_pkg SHALL hold EX3_OFFSET=3, EX3_MIN=3, EX3_MAX=12 and the default CNT_W.
REQ-024 One combinational sub-module ex3_decode SHALL compute {invalid, value} from e; the top holds the registers, counter and sticky flag.
REQ-025 No latches; all outputs driven directly from flops.

Verification
REQ-026 Sweep e=0..15 with in_valid=1 each cycle -> b sequence 11101,11110,11111,00000..01001,11010,11011,11100 one cycle later; err_cnt ends at 6.
REQ-027 e=3 then e=12 -> b=00000 then b=01001, err_sticky stays 0.
REQ-028 e=0 with in_valid=1 -> next cycle b=11101, out_valid=1, err_sticky=1, err_cnt=1.
REQ-029 Drive in_valid=0 with e=15 -> b unchanged, out_valid=0, err_cnt unchanged.
REQ-030 CNT_W=2, five consecutive e=14 -> err_cnt saturates at 3.
REQ-031 Assert rst_n=0 between edges while e=7 in flight -> b=00000, out_valid=0, counters 0 immediately; no output after release until next in_valid.
